tia_sync_ctrl: RTL and testbench

Beam-timing and CPU-halt controller for the TIA. Generates the NTSC color-clock horizontal counter, the scanline counter, the CPU clock-enable (one per three color clocks), and the RDY line that stalls the 6507 after a WSYNC strobe. It decodes CPU bus writes to the TIA sync registers (VSYNC, VBLANK, WSYNC, RSYNC) and supplies `xPos`, `ScanLine`, and blanking to the TIA pixel/color datapath.

---
 rtl/tia_sync_ctrl.sv | 132 +++++++++++++
 tb/tb_tia_sync_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tia_sync_ctrl.sv
// TIA beam timing: color-clock/scanline counters, CPU clock-enable and WSYNC halt.
// Optional RSYNC register (0x03) is built when TIA_RSYNC_EN is defined.
module tia_sync_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        R,
    input  logic [12:0] A,
    input  logic [7:0]  D,
    output logic        CpuEn,
    output logic        RDY,
    output logic [7:0]  HCount,
    output logic [7:0]  xPos,
    output logic [8:0]  ScanLine,
    output logic        HBlank,
    output logic        VBlank,
    output logic        VSync,
    output logic        Blank,
    output logic        LineStart
);

    localparam logic [7:0] LINE_LAST  = 8'd227;
    localparam logic [7:0] HBLANK_LEN = 8'd68;
    localparam logic [7:0] RSYNC_LOAD = 8'd225;
    localparam logic [8:0] SL_MAX     = 9'd511;

    localparam logic [5:0] REG_VSYNC  = 6'h00;
    localparam logic [5:0] REG_VBLANK = 6'h01;
    localparam logic [5:0] REG_WSYNC  = 6'h02;
`ifdef TIA_RSYNC_EN
    localparam logic [5:0] REG_RSYNC  = 6'h03;
`endif

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } halt_e;

    logic [1:0] phase_q, phase_d;
    logic       cpuen_q, cpuen_d;
    logic [7:0] hcount_q, hcount_d;
    logic [8:0] scanline_q, scanline_d;
    logic       vsync_q, vsync_d;
    logic       vblank_q, vblank_d;
    logic       rdy_q, rdy_d;
    halt_e      state_q, state_d;

    logic wr_en, wr_vsync, wr_vblank, wr_wsync, wr_rsync;
    logic line_end, vsync_fall;

    // Address/data bits outside the decoded sync registers.
    logic unused_bus;
    assign unused_bus = ^{A[11:8], A[6], D[7:2], D[0]};

    // Bus decode: writes land only on the CPU-enabled color clock.
    always_comb begin
        wr_en     = cpuen_q & ~R & ~A[12] & ~A[7];
        wr_vsync  = wr_en & (A[5:0] == REG_VSYNC);
        wr_vblank = wr_en & (A[5:0] == REG_VBLANK);
        wr_wsync  = wr_en & (A[5:0] == REG_WSYNC);
`ifdef TIA_RSYNC_EN
        wr_rsync  = wr_en & (A[5:0] == REG_RSYNC);
`else
        wr_rsync  = 1'b0;
`endif
        line_end   = (hcount_q == LINE_LAST);
        vsync_fall = wr_vsync & ~D[1] & vsync_q;
    end

    always_comb begin
        phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        cpuen_d = (phase_d == 2'd2);

        hcount_d = line_end ? 8'd0 : hcount_q + 8'd1;
        if (wr_rsync)
            hcount_d = RSYNC_LOAD;

        scanline_d = scanline_q;
        if (line_end && scanline_q != SL_MAX)
            scanline_d = scanline_q + 9'd1;
        if (vsync_fall)
            scanline_d = 9'd0;

        vsync_d  = wr_vsync  ? D[1] : vsync_q;
        vblank_d = wr_vblank ? D[1] : vblank_q;
    end

    // Halt FSM: a WSYNC accepted on the wrap edge wins over the release,
    // so the CPU stays stalled for the whole following line.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (wr_wsync) state_d = ST_HALT;
            ST_HALT: if (line_end && !wr_wsync) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        rdy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            phase_q    <= 2'd0;
            cpuen_q    <= 1'b0;
            hcount_q   <= 8'd0;
            scanline_q <= 9'd0;
            vsync_q    <= 1'b0;
            vblank_q   <= 1'b0;
            rdy_q      <= 1'b1;
            state_q    <= ST_RUN;
        end else begin
            phase_q    <= phase_d;
            cpuen_q    <= cpuen_d;
            hcount_q   <= hcount_d;
            scanline_q <= scanline_d;
            vsync_q    <= vsync_d;
            vblank_q   <= vblank_d;
            rdy_q      <= rdy_d;
            state_q    <= state_d;
        end
    end

    assign CpuEn     = cpuen_q;
    assign RDY       = rdy_q;
    assign HCount    = hcount_q;
    assign ScanLine  = scanline_q;
    assign VSync     = vsync_q;
    assign VBlank    = vblank_q;
    assign HBlank    = (hcount_q < HBLANK_LEN);
    assign xPos      = HBlank ? 8'd0 : hcount_q - HBLANK_LEN;
    assign Blank     = HBlank | vblank_q | vsync_q;
    assign LineStart = (hcount_q == 8'd0);

endmodule

// File: tb/tb_tia_sync_ctrl.sv
// Directed bench for tia_sync_ctrl: counters, bus decode, WSYNC halt, VSYNC, reset, RSYNC.
module tb_tia_sync_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        R;
    logic [12:0] A;
    logic [7:0]  D;
    logic        CpuEn, RDY, HBlank, VBlank, VSync, Blank, LineStart;
    logic [7:0]  HCount, xPos;
    logic [8:0]  ScanLine;

    int n_chk = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    tia_sync_ctrl dut (
        .Clk(Clk), .Reset(Reset), .R(R), .A(A), .D(D),
        .CpuEn(CpuEn), .RDY(RDY), .HCount(HCount), .xPos(xPos),
        .ScanLine(ScanLine), .HBlank(HBlank), .VBlank(VBlank),
        .VSync(VSync), .Blank(Blank), .LineStart(LineStart)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_hc(input int t);
        int g = 0;
        while (HCount != t[7:0] && g < 1000) begin
            tick();
            g++;
        end
        chk("wait_hc", 32'(HCount), 32'(t));
    endtask

    task automatic wait_sl(input int t);
        int g = 0;
        while (ScanLine != t[8:0] && g < 70000) begin
            tick();
            g++;
        end
        chk("wait_sl", 32'(ScanLine), 32'(t));
    endtask

    // Waits for the CPU-enabled clock, then presents one write for that edge.
    task automatic cpu_wr(input logic [12:0] a, input logic [7:0] d);
        int g = 0;
        while (!CpuEn && g < 5) begin
            tick();
            g++;
        end
        R = 1'b0; A = a; D = d;
        tick();
        R = 1'b1;
    endtask

    initial begin
        int cpuen_cnt, cpuen_bad, ls_cnt, hb_cnt, low_cnt, g;

        Reset = 1'b1; R = 1'b1; A = '0; D = '0;
        tick(); tick();
        chk("rst_cpuen",    32'(CpuEn),     0);
        chk("rst_rdy",      32'(RDY),       1);
        chk("rst_hcount",   32'(HCount),    0);
        chk("rst_scanline", 32'(ScanLine),  0);
        chk("rst_vsync",    32'(VSync),     0);
        chk("rst_vblank",   32'(VBlank),    0);
        chk("rst_hblank",   32'(HBlank),    1);
        chk("rst_blank",    32'(Blank),     1);
        chk("rst_xpos",     32'(xPos),      0);
        chk("rst_linestart",32'(LineStart), 1);
        Reset = 1'b0;

        // Free run for three lines.
        cpuen_cnt = 0; cpuen_bad = 0; ls_cnt = 0; hb_cnt = 0;
        for (int i = 0; i < 684; i++) begin
            if (CpuEn) cpuen_cnt++;
            if (CpuEn != (i % 3 == 2)) cpuen_bad++;
            if (LineStart) ls_cnt++;
            if (HBlank) hb_cnt++;
            tick();
        end
        chk("run_cpuen_cnt",  32'(cpuen_cnt), 228);
        chk("run_cpuen_patt", 32'(cpuen_bad), 0);
        chk("run_linestart",  32'(ls_cnt),    3);
        chk("run_hblank",     32'(hb_cnt),    204);
        chk("run_scanline",   32'(ScanLine),  3);
        chk("run_hcount",     32'(HCount),    0);

        // WSYNC mid-line: low for HCount 102..227.
        wait_hc(101);
        chk("ws_cpuen", 32'(CpuEn), 1);
        cpu_wr(13'h002, 8'hFF);
        chk("ws_hc_after", 32'(HCount), 102);
        chk("ws_rdy_low",  32'(RDY),    0);
        low_cnt = 0; g = 0;
        while (HCount != 8'd0 && g < 400) begin
            if (!RDY) low_cnt++;
            tick();
            g++;
        end
        chk("ws_low_cnt",  32'(low_cnt), 126);
        chk("ws_rdy_rel",  32'(RDY),     1);

        // WSYNC on the wrap edge: low for a full line.
        wait_hc(227);
        cpu_wr(13'h002, 8'h00);
        low_cnt = 0; g = 0;
        while (!RDY && g < 400) begin
            low_cnt++;
            tick();
            g++;
        end
        chk("ws_wrap_low", 32'(low_cnt), 228);
        chk("ws_wrap_hc",  32'(HCount),  0);

        // VSYNC falling edge clears the scanline.
        wait_sl(261);
        cpu_wr(13'h000, 8'h02);
        chk("vs_set",   32'(VSync),    1);
        chk("vs_blank", 32'(Blank),    1);
        chk("vs_sl261", 32'(ScanLine), 261);
        cpu_wr(13'h000, 8'h00);
        chk("vs_clr",   32'(VSync),    0);
        chk("vs_sl0",   32'(ScanLine), 0);
        wait_hc(20);
        cpu_wr(13'h000, 8'h00);
        wait_hc(30);
        cpu_wr(13'h000, 8'h00);
        chk("vs_noedge_sl", 32'(ScanLine), 0);

        // VBLANK write, mirrored/read/high-address accesses ignored.
        wait_hc(68);
        chk("xpos_68", 32'(xPos), 0);
        cpu_wr(13'h001, 8'h02);
        chk("vb_set",    32'(VBlank), 1);
        chk("vb_hblank", 32'(HBlank), 0);
        chk("vb_blank",  32'(Blank),  1);
        cpu_wr(13'h081, 8'h00);
        chk("vb_mirror", 32'(VBlank), 1);
        R = 1'b1; A = 13'h001; D = 8'h00;
        tick(); tick(); tick();
        chk("vb_read",   32'(VBlank), 1);
        cpu_wr(13'h1001, 8'h00);
        chk("vb_a12",    32'(VBlank), 1);
        wait_hc(227);
        chk("xpos_227",  32'(xPos),   159);
        cpu_wr(13'h001, 8'h00);
        wait_hc(100);
        chk("vb_clr",    32'(VBlank), 0);
        chk("blank_vis", 32'(Blank),  0);
        chk("xpos_100",  32'(xPos),   32);

        // Reset while halted at scanline 40.
        wait_sl(40);
        cpu_wr(13'h000, 8'h02);
        cpu_wr(13'h001, 8'h02);
        cpu_wr(13'h002, 8'h00);
        chk("mh_rdy",    32'(RDY),      0);
        chk("mh_sl",     32'(ScanLine), 40);
        Reset = 1'b1;
        tick();
        chk("mr_rdy",    32'(RDY),      1);
        chk("mr_sl",     32'(ScanLine), 0);
        chk("mr_hc",     32'(HCount),   0);
        chk("mr_vsync",  32'(VSync),    0);
        chk("mr_vblank", 32'(VBlank),   0);
        Reset = 1'b0;

        // RSYNC at HCount 50.
        wait_hc(50);
        cpu_wr(13'h003, 8'h00);
`ifdef TIA_RSYNC_EN
        chk("rs_hc0", 32'(HCount), 225);
        tick();
        chk("rs_hc1", 32'(HCount), 226);
        tick();
        chk("rs_hc2", 32'(HCount), 227);
        tick();
        chk("rs_hc3", 32'(HCount), 0);
        chk("rs_sl",  32'(ScanLine), 1);
`else
        chk("rs_hc0", 32'(HCount), 51);
        tick(); tick(); tick();
        chk("rs_hc3", 32'(HCount), 54);
        chk("rs_sl",  32'(ScanLine), 0);
`endif

        // Halt from before reset must not reappear.
        low_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (!RDY) low_cnt++;
            tick();
        end
        chk("mr_no_halt", 32'(low_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
